fib_sequencer: RTL and testbench

- Parametrised Fibonacci sequence controller that drives the processor's control inputs (op, sourceReg, destReg, regEnable, immControl, immediate, flagWrite).
- Generalises the fixed 16-step sequencer with:
  - a start/busy/done handshake;
  - runtime seeds and term count;
  - ring-buffer wrap across the register file;
  - overflow-stop.
- Sits between the board top level and processor; the display mux is driven from last_reg.

---
 rtl/fib_pkg.sv | 25 ++
 rtl/fib_ctrl_word.sv | 100 ++++++++++
 rtl/fib_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fib_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: processor opcodes, the
// sequencer state encoding and a one-hot register-enable helper.
package fib_pkg;

  localparam logic [3:0] OP_MOVE = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0100;

  // Widest register file the one-hot helper can address (8-bit index).
  localparam int ONEHOT_MAX_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One-hot write enable for register idx; callers size-cast to NUM_REGS.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [7:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/fib_ctrl_word.sv
// Registered encoder for the processor control bus. It is fed the state and
// term index that will be current in the next cycle, so the word it registers
// lines up with the sequencer's own state register.
module fib_ctrl_word
  import fib_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  state_t              state,
  input  logic [IDX_W-1:0]    k_idx,
  input  logic [DATA_W-1:0]   seed0,
  input  logic [DATA_W-1:0]   seed1,
  output logic [3:0]          op,
  output logic [IDX_W-1:0]    sourceReg,
  output logic [IDX_W-1:0]    destReg,
  output logic [NUM_REGS-1:0] regEnable,
  output logic                immControl,
  output logic [DATA_W-1:0]   immediate,
  output logic                flagWrite
);

  logic [3:0]          w_op,        r_op;
  logic [IDX_W-1:0]    w_src,       r_src;
  logic [IDX_W-1:0]    w_dst,       r_dst;
  logic [NUM_REGS-1:0] w_en,        r_en;
  logic                w_imm_ctrl,  r_imm_ctrl;
  logic [DATA_W-1:0]   w_imm,       r_imm;
  logic                w_flag,      r_flag;

  // Decode the upcoming state into a control word; anything that is not a
  // term word is the quiescent word.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    w_op       = OP_ADD;
    w_src      = '0;
    w_dst      = '0;
    w_en       = '0;
    w_imm_ctrl = 1'b0;
    w_imm      = '0;
    w_flag     = 1'b0;
    unique case (state)
      ST_LOAD0: begin
        w_op       = OP_MOVE;
        w_imm_ctrl = 1'b1;
        w_imm      = seed0;
        w_en       = NUM_REGS'(onehot(8'd0));
      end
      ST_LOAD1: begin
        w_op       = OP_MOVE;
        w_imm_ctrl = 1'b1;
        w_imm      = seed1;
        w_en       = NUM_REGS'(onehot(8'd1));
      end
      ST_STEP: begin
        // Indices wrap at IDX_W bits, giving the ring-buffer behaviour.
        w_op   = OP_ADD;
        w_src  = k_idx - IDX_W'(2);
        w_dst  = k_idx - IDX_W'(1);
        w_en   = NUM_REGS'(onehot(8'(k_idx)));
        w_flag = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register for the control bus; reset forces the quiescent word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= OP_ADD;
      r_src      <= '0;
      r_dst      <= '0;
      r_en       <= '0;
      r_imm_ctrl <= 1'b0;
      r_imm      <= '0;
      r_flag     <= 1'b0;
    end else begin
      r_op       <= w_op;
      r_src      <= w_src;
      r_dst      <= w_dst;
      r_en       <= w_en;
      r_imm_ctrl <= w_imm_ctrl;
      r_imm      <= w_imm;
      r_flag     <= w_flag;
    end
  end

  assign op         = r_op;
  assign sourceReg  = r_src;
  assign destReg    = r_dst;
  assign regEnable  = r_en;
  assign immControl = r_imm_ctrl;
  assign immediate  = r_imm;
  assign flagWrite  = r_flag;

endmodule

// File: rtl/fib_sequencer.sv
// Fibonacci sequence controller: runs a start/busy/done handshake, issues one
// control word per term into a ring buffer of processor registers, and stops
// early when the next term would not fit in DATA_W bits.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_terms,
  input  logic [DATA_W-1:0]   seed0,
  input  logic [DATA_W-1:0]   seed1,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [CNT_W-1:0]    term_count,
  output logic [IDX_W-1:0]    last_reg,
  output logic [3:0]          op,
  output logic [IDX_W-1:0]    sourceReg,
  output logic [IDX_W-1:0]    destReg,
  output logic [NUM_REGS-1:0] regEnable,
  output logic                immControl,
  output logic [DATA_W-1:0]   immediate,
  output logic                flagWrite
);

  state_t            r_state, w_next_state;
  logic [CNT_W-1:0]  r_k, w_k_next;       // term whose word is on the bus
  logic [CNT_W-1:0]  r_n, w_n_clamped;
  logic [CNT_W-1:0]  r_term_count;
  logic [IDX_W-1:0]  r_last_reg;
  logic [DATA_W-1:0] r_a, r_b;            // shadows of terms k-2 and k-1
  logic [DATA_W:0]   w_sum;
  logic              w_next_carry;
  logic              w_accept, w_issuing, w_ovf_stop;
  logic              r_busy, r_done, r_overflow;

  assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_issuing   = (r_state == ST_LOAD0) || (r_state == ST_LOAD1) ||
                       (r_state == ST_STEP);
  assign w_n_clamped = (num_terms < CNT_W'(2)) ? CNT_W'(2) : num_terms;

  // w_sum is the current term in STEP (and term 2 while in LOAD1). The term
  // after it is b + sum, which carries exactly when sum exceeds ~b.
  assign w_sum        = {1'b0, r_a} + {1'b0, r_b};
  assign w_next_carry = (w_sum[DATA_W-1:0] > ~r_b);

  // Next-state logic: decide the next term to issue, or stop.
  always_comb begin
    w_next_state = r_state;
    w_k_next     = r_k;
    w_ovf_stop   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next_state = ST_LOAD0;
          w_k_next     = '0;
        end
      end
      ST_LOAD0: begin
        w_next_state = ST_LOAD1;
        w_k_next     = CNT_W'(1);
      end
      ST_LOAD1: begin
        if (r_n == CNT_W'(2)) begin
          w_next_state = ST_DONE;
        end else if (w_sum[DATA_W]) begin
          w_next_state = ST_DONE;
          w_ovf_stop   = 1'b1;
        end else begin
          w_next_state = ST_STEP;
          w_k_next     = CNT_W'(2);
        end
      end
      ST_STEP: begin
        if (r_k + CNT_W'(1) == r_n) begin
          w_next_state = ST_DONE;
        end else if (w_next_carry) begin
          w_next_state = ST_DONE;
          w_ovf_stop   = 1'b1;
        end else begin
          w_k_next = r_k + CNT_W'(1);
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, handshake flags and write counters.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples values from before the edge, independent of order.
    if (reset) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_term_count <= '0;
      r_last_reg   <= '0;
    end else begin
      r_state <= w_next_state;
      r_k     <= w_k_next;
      r_busy  <= (w_next_state == ST_LOAD0) || (w_next_state == ST_LOAD1) ||
                 (w_next_state == ST_STEP);
      r_done  <= (w_next_state == ST_DONE);
      if (w_accept) begin
        r_overflow   <= 1'b0;
        r_term_count <= '0;
      end else if (w_issuing) begin
        // The word on the bus this cycle is written by the processor now.
        r_term_count <= r_term_count + CNT_W'(1);
        r_last_reg   <= r_k[IDX_W-1:0];
      end
      if (w_ovf_stop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Run parameters and term shadows, loaded at start and shifted per ADD.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers are deliberately not reset: they are
    // always loaded at start before anything reads them.
    if (w_accept) begin
      r_n <= w_n_clamped;
      r_a <= seed0;
      r_b <= seed1;
    end else if (r_state == ST_STEP) begin
      r_a <= r_b;
      r_b <= w_sum[DATA_W-1:0];
    end
  end

  // seed0 comes straight from the port because LOAD0's word is registered on
  // the accepting edge; seed1 comes from the latched shadow one edge later.
  fib_ctrl_word #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_ctrl_word (
    .clk        (clk),
    .reset      (reset),
    .state      (w_next_state),
    .k_idx      (w_k_next[IDX_W-1:0]),
    .seed0      (seed0),
    .seed1      (r_b),
    .op         (op),
    .sourceReg  (sourceReg),
    .destReg    (destReg),
    .regEnable  (regEnable),
    .immControl (immControl),
    .immediate  (immediate),
    .flagWrite  (flagWrite)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign term_count = r_term_count;
  assign last_reg   = r_last_reg;

endmodule

// File: tb/tb_fib_sequencer.sv
// Bench for fib_sequencer: a small processor register-file model consumes the
// control bus, and each run is compared against Fibonacci terms computed with
// plain arithmetic.
module tb_fib_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  num_terms;
  logic [15:0] seed0, seed1;
  logic        busy, done, overflow;
  logic [7:0]  term_count;
  logic [3:0]  last_reg;
  logic [3:0]  op;
  logic [3:0]  sourceReg, destReg;
  logic [15:0] regEnable;
  logic        immControl;
  logic [15:0] immediate;
  logic        flagWrite;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] pr [16];

  fib_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_terms  (num_terms),
    .seed0      (seed0),
    .seed1      (seed1),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .term_count (term_count),
    .last_reg   (last_reg),
    .op         (op),
    .sourceReg  (sourceReg),
    .destReg    (destReg),
    .regEnable  (regEnable),
    .immControl (immControl),
    .immediate  (immediate),
    .flagWrite  (flagWrite)
  );

  always #5 clk = ~clk;

  // Processor register file: executes whatever word is on the bus.
  always @(posedge clk) begin : proc_model
    logic [15:0] opb, res;
    opb = immControl ? immediate : pr[destReg];
    if (op == 4'b0001) res = opb;
    else               res = pr[sourceReg] + opb;
    for (int i = 0; i < 16; i++)
      if (regEnable[i]) pr[i] <= res;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] bus_word();
    return {op, sourceReg, destReg, regEnable, immControl, immediate, flagWrite};
  endfunction

  localparam logic [45:0] QUIET = {4'b0100, 42'd0};

  function automatic logic [45:0] exp_word(input int k, input logic [15:0] s0, input logic [15:0] s1);
    if (k == 0) return {4'b0001, 4'd0, 4'd0, 16'h0001, 1'b1, s0, 1'b0};
    if (k == 1) return {4'b0001, 4'd0, 4'd0, 16'h0002, 1'b1, s1, 1'b0};
    return {4'b0100, 4'((k - 2) % 16), 4'((k - 1) % 16), 16'(32'd1 << (k % 16)),
            1'b0, 16'h0000, 1'b1};
  endfunction

  // One run: mid_k pulses start during that word cycle, rst_k resets after
  // that word cycle (-1 disables either).
  task automatic run(input int n_in, input logic [15:0] s0, input logic [15:0] s1,
                     input int mid_k, input int rst_k);
    longint t[$];
    int n, written;
    bit ovf;
    n = (n_in < 2) ? 2 : n_in;
    t.push_back(longint'(s0));
    t.push_back(longint'(s1));
    written = n;
    for (int k = 2; k < n; k++) begin
      if (t[k-2] + t[k-1] > 65535) begin
        written = k;
        break;
      end
      t.push_back(t[k-2] + t[k-1]);
    end
    ovf = (written < n);

    @(negedge clk);
    num_terms = 8'(n_in);
    seed0     = s0;
    seed1     = s1;
    start     = 1'b1;
    for (int k = 0; k < written; k++) begin
      @(negedge clk);
      start     = (k == mid_k);
      seed0     = 16'($urandom);
      seed1     = 16'($urandom);
      num_terms = 8'($urandom);
      check($sformatf("word[%0d]", k), bus_word(), exp_word(k, s0, s1));
      check($sformatf("busy_done[%0d]", k), {busy, done}, 2'b10);
      check($sformatf("term_count[%0d]", k), term_count, 64'(k));
      if (k > 0) check($sformatf("last_reg[%0d]", k), last_reg, 64'((k - 1) % 16));
      if (k == rst_k) begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_regEnable", regEnable, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_term_count", term_count, 0);
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("end_busy_done", {busy, done}, 2'b01);
    check("end_word", bus_word(), QUIET);
    check("end_term_count", term_count, 64'(written));
    check("end_last_reg", last_reg, 64'((written - 1) % 16));
    check("end_overflow", overflow, 64'(ovf));
    check("end_r_last", pr[(written - 1) % 16], 64'(t[written-1]));
    check("end_r_prev", pr[(written - 2) % 16], 64'(t[written-2]));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    num_terms = '0;
    seed0     = '0;
    seed1     = '0;
    repeat (2) @(negedge clk);
    check("reset_word", bus_word(), QUIET);
    check("reset_flags", {busy, done, overflow}, 0);
    check("reset_term_count", term_count, 0);
    check("reset_last_reg", last_reg, 0);
    reset = 1'b0;

    run(16, 16'd0, 16'd1, -1, -1);                      // nominal
    check("nominal_r15", pr[15], 610);
    check("nominal_r14", pr[14], 377);
    run(20, 16'd0, 16'd1, -1, -1);                      // ring wrap
    check("wrap_r3", pr[3], 4181);
    run(30, 16'd0, 16'd1, -1, -1);                      // overflow stop
    check("ovf_flag", overflow, 1);
    check("ovf_r8", pr[8], 46368);
    run(0, 16'd5, 16'd7, -1, -1);                       // clamp
    check("clamp_r0", pr[0], 5);
    check("clamp_r1", pr[1], 7);
    run(1, 16'd100, 16'd200, -1, -1);
    run(16, 16'd0, 16'd1, 3, 6);                        // mid-run start, then reset
    run(5, 16'd1, 16'd1, -1, -1);                       // clean run after reset
    run(5, 16'd2, 16'd3, -1, -1);                       // restart from DONE
    check("restart_r4", pr[4], 13);

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_start_flags", {busy, done}, 0);
    check("rst_start_word", bus_word(), QUIET);
    start = 1'b0;
    reset = 1'b0;

    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0)
        run(int'($urandom_range(0, 40)), 16'($urandom_range(0, 50)),
            16'($urandom_range(0, 50)), -1, -1);
      else
        run(int'($urandom_range(0, 40)), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 3)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
